wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter MS_TO_WS_BUS_WD, 87, width of the MEM-to-WB bus.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ms_to_ws_valid  input  1  MEM stage holds a valid instruction.
REQ-005 ms_to_ws_bus  input  87  {cp0_addr[86:79] = rd,sel; ex[78]; bd[77]; eret[76]; syscall[75]; mfc0[74]; mtc0[73]; gr_strb[72:69]; dest[68:64]; result[63:32]; pc[31:0]}.
REQ-006 ws_allowin  output  1  WB can accept an instruction.
REQ-007 rf_we  output  4  per-byte register-file write strobe.
REQ-008 rf_waddr  output  5  register-file write address.
REQ-009 rf_wdata  output  32  register-file write data.
REQ-010 ws_fwd_blk_bus  output  41  {fwd_valid[40:37], dest[36:32], data[31:0]} for decode forwarding and blocking.
REQ-011 ws_ex  output  1  committing instruction raises an exception.
REQ-012 eret_flush  output  1  committing ERET.
REQ-013 cp0_epc  output  32  current EPC, the ERET target.
REQ-014 has_int  output  1  pending enabled interrupt, to decode.
REQ-015 debug_wb_pc/_rf_wen[3:0]/_rf_wnum[4:0]/_rf_wdata[31:0]  output  trace, equal to pc, rf_we, rf_waddr, rf_wdata.

Function
REQ-016 ready_go = 1; ws_allowin = !ws_valid || ready_go.
REQ-017 When ws_allowin, ws_valid <= ms_to_ws_valid; bus register loads only when ms_to_ws_valid && ws_allowin.
REQ-018 rf_we = gr_strb & {4{ws_valid && !ex}}; rf_waddr = dest.
REQ-019 rf_wdata = CP0 read data when mfc0, else result.
REQ-020 ws_fwd_blk_bus carries rf_we, dest, rf_wdata; fwd_valid is 0 when !ws_valid.
REQ-021 ws_ex = ws_valid && ex; eret_flush = ws_valid && eret; both combinational, same cycle as commit.
REQ-022 CP0 addresses: Count 9,0; Compare 11,0; Status 12,0; Cause 13,0; EPC 14,0. Reads of any other address return 0.
REQ-023 Status: bit22 BEV reads 1; IM[15:8], EXL[1], IE[0] writable; other bits read 0.
REQ-024 Cause: BD[31] and TI[30] read-only; IP[15:10] hardware (IP7 = TI, IP[6:2] = 0); IP[9:8] writable; ExcCode[6:2]; other bits read 0.
REQ-025 An MTC0 write occurs only when ws_valid && mtc0 && !ex; write data is result.
REQ-026 On ws_ex, all of the following SHALL take effect in the same cycle:
  - EXL <= 1.
  - BD <= bd.
  - ExcCode <= 0x08 if syscall, else 0x00.
  - If EXL was 0: EPC <= bd ? pc-4 : pc.
  - If EXL was already 1: EPC is unchanged.
REQ-027 On eret_flush, EXL <= 0.
REQ-028 A 1-bit tick toggles every cycle; Count increments when tick = 1, so it advances once per two cycles and wraps 0xFFFFFFFF -> 0.
REQ-029 An MTC0 to Count in the same cycle as an increment: the MTC0 data wins.
REQ-030 TI <= 1 when Count == Compare (compared after update) and Compare != its reset-time match suppression; TI <= 0 on any MTC0 to Compare, which wins over a simultaneous match.
REQ-031 has_int = IE && !EXL && |(IM & IP[15:8]).
REQ-032 ws_ex and MTC0 are mutually exclusive per REQ-025; exception updates SHALL override any MTC0 to Status, Cause or EPC.

Reset
REQ-033 While reset is high:
  - ws_valid = 0, so rf_we = 0, fwd_valid = 0, ws_ex = 0, eret_flush = 0.
  - Status = 0x00400000; Cause = 0; EPC = 0; Count = 0; Compare = 0; tick = 0.
REQ-034 A reset mid-instruction discards the held instruction; no register-file write and no CP0 update occur.

Verification
REQ-035 Load with gr_strb = 4'b1100, dest = 5, result = 0xAABBCCDD -> one cycle later rf_we = 1100, rf_waddr = 5, rf_wdata = 0xAABBCCDD, fwd_valid = 1100.
REQ-036 Syscall with bd = 1, pc = 0xBFC00104 -> ws_ex = 1, rf_we = 0; next cycle EPC = 0xBFC00100, Cause.BD = 1, ExcCode = 8, Status = 0x00400002.
REQ-037 ERET with EXL = 1, EPC = 0x80001000 -> eret_flush = 1, cp0_epc = 0x80001000; next cycle EXL = 0.
REQ-038 MTC0 Compare = 10 after reset -> Count reaches 10 at cycle ~21, then TI = 1; with IM7 = 1, IE = 1, EXL = 0, has_int = 1; MTC0 Compare clears TI.
REQ-039 MTC0 Status = 0xFFFFFFFF -> MFC0 Status returns 0x0040FF03; MFC0 at address 15,0 returns 0.
REQ-040 ms_to_ws_valid pulsed, then reset asserted while ws_valid = 1 -> rf_we = 0 and CP0 holds its reset values.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS-style write-back stage with CP0 (Status/Cause/EPC/Count/Compare)
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   ms_to_ws_valid/_bus     instruction handed over from MEM
//   ws_allowin              WB can accept an instruction
//   rf_we/rf_waddr/rf_wdata register-file byte-strobed write port
//   ws_fwd_blk_bus          {fwd_valid, dest, data} for decode forwarding/blocking
//   ws_ex, eret_flush       exception / ERET commit, combinational in the commit cycle
//   cp0_epc                 current EPC (ERET target)
//   has_int                 pending enabled interrupt
//   debug_wb_*              commit trace
module wb_stage #(
  parameter int MS_TO_WS_BUS_WD = 87
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [40:0]                ws_fwd_blk_bus,
  output logic                       ws_ex,
  output logic                       eret_flush,
  output logic [31:0]                cp0_epc,
  output logic                       has_int,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  // CP0 addresses as {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC     = {5'd14, 3'd0};

  logic                       ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] bus_r;
  logic                       ready_go;

  logic [7:0]  cp0_addr;
  logic        ex, bd, eret, syscall, mfc0, mtc0;
  logic [3:0]  gr_strb;
  logic [4:0]  dest;
  logic [31:0] result, pc;

  assign cp0_addr = bus_r[86:79];
  assign ex       = bus_r[78];
  assign bd       = bus_r[77];
  assign eret     = bus_r[76];
  assign syscall  = bus_r[75];
  assign mfc0     = bus_r[74];
  assign mtc0     = bus_r[73];
  assign gr_strb  = bus_r[72:69];
  assign dest     = bus_r[68:64];
  assign result   = bus_r[63:32];
  assign pc       = bus_r[31:0];

  // WB always completes in one cycle.
  assign ready_go   = 1'b1;
  assign ws_allowin = !ws_valid || ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      bus_r <= ms_to_ws_bus;
    end
  end

  // CP0 state
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;
  // Compare and Count both reset to 0; the timer stays quiet until software
  // has actually programmed Compare, so that trivial match does not fire.
  logic        compare_armed;

  logic        mtc0_we;
  logic [31:0] count_upd;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] cp0_rdata;

  assign ws_ex      = ws_valid && ex;
  assign eret_flush = ws_valid && eret;
  assign mtc0_we    = ws_valid && mtc0 && !ex;

  assign status_rd = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  // IP7 mirrors the timer interrupt; IP6..IP2 have no external sources here.
  assign cause_rd  = {cause_bd, cause_ti, 14'b0, cause_ti, 5'b0, cause_ip_sw,
                      1'b0, cause_exccode, 2'b0};

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = count;
      ADDR_COMPARE: cp0_rdata = compare;
      ADDR_STATUS:  cp0_rdata = status_rd;
      ADDR_CAUSE:   cp0_rdata = cause_rd;
      ADDR_EPC:     cp0_rdata = epc;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  // Count value after this edge; the timer match looks at the updated value.
  always_comb begin
    count_upd = count + {31'b0, tick};
    if (mtc0_we && cp0_addr == ADDR_COUNT) begin
      count_upd = result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im     <= 8'h0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip_sw   <= 2'b0;
      cause_exccode <= 5'h0;
      epc           <= 32'h0;
      count         <= 32'h0;
      compare       <= 32'h0;
      tick          <= 1'b0;
      compare_armed <= 1'b0;
    end else begin
      tick  <= ~tick;
      count <= count_upd;

      if (mtc0_we && cp0_addr == ADDR_COMPARE) begin
        compare       <= result;
        compare_armed <= 1'b1;
        cause_ti      <= 1'b0;
      end else if (compare_armed && count_upd == compare) begin
        cause_ti <= 1'b1;
      end

      if (mtc0_we && cp0_addr == ADDR_STATUS) begin
        status_im  <= result[15:8];
        status_exl <= result[1];
        status_ie  <= result[0];
      end
      if (mtc0_we && cp0_addr == ADDR_CAUSE) begin
        cause_ip_sw <= result[9:8];
      end
      if (mtc0_we && cp0_addr == ADDR_EPC) begin
        epc <= result;
      end

      if (eret_flush) begin
        status_exl <= 1'b0;
      end

      // Exception commit comes last so it overrides everything above.
      if (ws_ex) begin
        status_exl    <= 1'b1;
        cause_bd      <= bd;
        cause_exccode <= syscall ? 5'h08 : 5'h00;
        // Nested exceptions keep the original return address.
        if (!status_exl) begin
          epc <= bd ? (pc - 32'd4) : pc;
        end
      end
    end
  end

  assign cp0_epc = epc;
  assign has_int = status_ie && !status_exl && |(status_im & cause_rd[15:8]);

  assign rf_we    = gr_strb & {4{ws_valid && !ex}};
  assign rf_waddr = dest;
  assign rf_wdata = mfc0 ? cp0_rdata : result;

  assign ws_fwd_blk_bus = {rf_we, rf_waddr, rf_wdata};

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a CP0 reference model
module tb_wb_stage;

  localparam logic [7:0] A_CNT = 8'h48;
  localparam logic [7:0] A_CMP = 8'h58;
  localparam logic [7:0] A_ST  = 8'h60;
  localparam logic [7:0] A_CA  = 8'h68;
  localparam logic [7:0] A_EPC = 8'h70;
  localparam logic [7:0] A_BAD = 8'h78;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [86:0] ms_to_ws_bus;
  logic        ws_allowin;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [40:0] ws_fwd_blk_bus;
  logic        ws_ex;
  logic        eret_flush;
  logic [31:0] cp0_epc;
  logic        has_int;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_stage #(.MS_TO_WS_BUS_WD(87)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_blk_bus(ws_fwd_blk_bus), .ws_ex(ws_ex), .eret_flush(eret_flush),
    .cp0_epc(cp0_epc), .has_int(has_int),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: architectural CP0 registers as whole words.
  // m_cause keeps TI in bit 30; the IP7 view is added on read.
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
  logic        m_tick, m_armed, m_valid;
  logic [86:0] m_bus;

  function automatic logic [86:0] mk(input logic [7:0] a, input logic ex, input logic bd,
                                     input logic eret, input logic sys, input logic mfc0,
                                     input logic mtc0, input logic [3:0] strb,
                                     input logic [4:0] dest, input logic [31:0] res,
                                     input logic [31:0] pc);
    return {a, ex, bd, eret, sys, mfc0, mtc0, strb, dest, res, pc};
  endfunction

  function automatic logic [31:0] cp0_read(input logic [7:0] a);
    case (a)
      A_CNT:   return m_count;
      A_CMP:   return m_compare;
      A_ST:    return m_status;
      A_CA:    return m_cause | (32'(m_cause[30]) << 15);
      A_EPC:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_has_int();
    logic [31:0] c;
    c = cp0_read(A_CA);
    return m_status[0] && !m_status[1] && (|(m_status[15:8] & c[15:8]));
  endfunction

  function automatic logic [3:0] exp_we();
    return (m_valid && !m_bus[78]) ? m_bus[72:69] : 4'h0;
  endfunction

  function automatic logic [31:0] exp_wdata();
    return m_bus[74] ? cp0_read(m_bus[86:79]) : m_bus[63:32];
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
    m_tick = 0; m_armed = 0; m_valid = 0;
  endtask

  task automatic model_commit();
    logic [7:0]  a;
    logic [31:0] res, pc, new_count;
    logic        ex, we, old_exl, set_ti;
    a   = m_bus[86:79];
    res = m_bus[63:32];
    pc  = m_bus[31:0];
    ex  = m_valid && m_bus[78];
    we  = m_valid && m_bus[73] && !ex;
    old_exl = m_status[1];
    new_count = m_count + 32'(m_tick);
    m_tick = !m_tick;
    if (we && a == A_CNT) new_count = res;
    set_ti = m_armed && (new_count == m_compare);
    m_count = new_count;
    if (we && a == A_CMP) begin
      m_compare = res; m_armed = 1; m_cause[30] = 0;
    end else if (set_ti) begin
      m_cause[30] = 1;
    end
    if (we && a == A_ST)  m_status = 32'h0040_0000 | (res & 32'h0000_FF03);
    if (we && a == A_CA)  m_cause  = (m_cause & ~32'h300) | (res & 32'h300);
    if (we && a == A_EPC) m_epc    = res;
    if (m_valid && m_bus[76]) m_status[1] = 0;
    if (ex) begin
      if (!old_exl) m_epc = m_bus[77] ? pc - 32'd4 : pc;
      m_status[1] = 1;
      m_cause[31] = m_bus[77];
      m_cause[6:2] = m_bus[75] ? 5'h08 : 5'h00;
    end
  endtask

  // One clock: present an instruction, advance DUT and model, settle past the edge.
  task automatic step(input logic v, input logic [86:0] b);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      model_commit();
      m_valid = v;
      if (v) m_bus = b;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    step(0, '0);
    step(0, '0);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    step(0, '0);
    step(0, '0);
    vectors++; if (rf_we !== 4'h0) begin errors++; $display("FAIL reset_rf_we: got %h want 0", rf_we); end
    vectors++; if (ws_fwd_blk_bus[40:37] !== 4'h0) begin errors++; $display("FAIL reset_fwd_valid: got %h want 0", ws_fwd_blk_bus[40:37]); end
    vectors++; if (ws_ex !== 1'b0 || eret_flush !== 1'b0) begin errors++; $display("FAIL reset_ex_eret: got %b%b want 00", ws_ex, eret_flush); end
    vectors++; if (cp0_epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", cp0_epc); end
    vectors++; if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int: got %b want 0", has_int); end
    vectors++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ws_allowin); end
    reset = 0;
    step(1, mk(A_ST, 0,0,0,0,1,0, 4'hF, 5'd2, 32'h0, 32'h100));
    vectors++; if (rf_wdata !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h want 00400000", rf_wdata); end
    step(1, mk(A_CA, 0,0,0,0,1,0, 4'hF, 5'd2, 32'h0, 32'h104));
    vectors++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 0", rf_wdata); end
  endtask

  task automatic test_load();
    step(1, mk(8'h0, 0,0,0,0,0,0, 4'b1100, 5'd5, 32'hAABB_CCDD, 32'h0000_1000));
    vectors++; if (rf_we !== 4'b1100) begin errors++; $display("FAIL load_rf_we: got %b want 1100", rf_we); end
    vectors++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL load_rf_waddr: got %0d want 5", rf_waddr); end
    vectors++; if (rf_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL load_rf_wdata: got %h want aabbccdd", rf_wdata); end
    vectors++; if (ws_fwd_blk_bus !== {4'b1100, 5'd5, 32'hAABB_CCDD}) begin errors++; $display("FAIL load_fwd_bus: got %h", ws_fwd_blk_bus); end
    vectors++; if (debug_wb_pc !== 32'h1000 || debug_wb_rf_wen !== 4'b1100) begin errors++; $display("FAIL load_debug: got pc %h wen %b want 1000 1100", debug_wb_pc, debug_wb_rf_wen); end
    step(0, '0);
    vectors++; if (rf_we !== 4'h0 || ws_fwd_blk_bus[40:37] !== 4'h0) begin errors++; $display("FAIL bubble_we: got %b/%b want 0", rf_we, ws_fwd_blk_bus[40:37]); end
  endtask

  task automatic test_syscall();
    step(1, mk(8'h0, 1,1,0,1,0,0, 4'hF, 5'd3, 32'h5, 32'hBFC0_0104));
    vectors++; if (ws_ex !== 1'b1) begin errors++; $display("FAIL sys_ws_ex: got %b want 1", ws_ex); end
    vectors++; if (rf_we !== 4'h0) begin errors++; $display("FAIL sys_rf_we: got %b want 0", rf_we); end
    step(1, mk(A_CA, 0,0,0,0,1,0, 4'hF, 5'd4, 32'h0, 32'hBFC0_0380));
    vectors++; if (cp0_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL sys_epc: got %h want bfc00100", cp0_epc); end
    vectors++; if (rf_wdata !== 32'h8000_0020) begin errors++; $display("FAIL sys_cause: got %h want 80000020", rf_wdata); end
    step(1, mk(A_ST, 0,0,0,0,1,0, 4'hF, 5'd4, 32'h0, 32'hBFC0_0384));
    vectors++; if (rf_wdata !== 32'h0040_0002) begin errors++; $display("FAIL sys_status: got %h want 00400002", rf_wdata); end
    // Nested exception with EXL already set: EPC must hold, ExcCode/BD still update.
    step(1, mk(8'h0, 1,0,0,0,0,0, 4'h0, 5'd0, 32'h0, 32'h0000_0200));
    step(1, mk(A_CA, 0,0,0,0,1,0, 4'hF, 5'd4, 32'h0, 32'hBFC0_0388));
    vectors++; if (cp0_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL nested_epc: got %h want bfc00100", cp0_epc); end
    vectors++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL nested_cause: got %h want 0", rf_wdata); end
  endtask

  task automatic test_eret();
    step(1, mk(A_EPC, 0,0,0,0,0,1, 4'h0, 5'd0, 32'h8000_1000, 32'h300));
    step(1, mk(A_ST,  0,0,0,0,0,1, 4'h0, 5'd0, 32'h0000_0002, 32'h304));
    step(1, mk(8'h0,  0,0,1,0,0,0, 4'h0, 5'd0, 32'h0, 32'h308));
    vectors++; if (eret_flush !== 1'b1) begin errors++; $display("FAIL eret_flush: got %b want 1", eret_flush); end
    vectors++; if (cp0_epc !== 32'h8000_1000) begin errors++; $display("FAIL eret_epc: got %h want 80001000", cp0_epc); end
    step(1, mk(A_ST, 0,0,0,0,1,0, 4'hF, 5'd6, 32'h0, 32'h8000_1000));
    vectors++; if (eret_flush !== 1'b0) begin errors++; $display("FAIL eret_clear: got %b want 0", eret_flush); end
    vectors++; if (rf_wdata !== 32'h0040_0000) begin errors++; $display("FAIL eret_exl: got %h want 00400000", rf_wdata); end
  endtask

  task automatic test_mfc0_masks();
    step(1, mk(A_ST,  0,0,0,0,0,1, 4'h0, 5'd0, 32'hFFFF_FFFF, 32'h400));
    step(1, mk(A_ST,  0,0,0,0,1,0, 4'hF, 5'd7, 32'h0, 32'h404));
    vectors++; if (rf_wdata !== 32'h0040_FF03) begin errors++; $display("FAIL status_mask: got %h want 0040ff03", rf_wdata); end
    vectors++; if (has_int !== 1'b0) begin errors++; $display("FAIL exl_blocks_int: got %b want 0", has_int); end
    step(1, mk(A_BAD, 0,0,0,0,1,0, 4'hF, 5'd7, 32'h1234_5678, 32'h408));
    vectors++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL bad_addr_read: got %h want 0", rf_wdata); end
    step(1, mk(A_ST,  0,0,0,0,0,1, 4'h0, 5'd0, 32'h0, 32'h40C));
  endtask

  task automatic test_timer();
    int first;
    do_reset();
    step(1, mk(A_ST,  0,0,0,0,0,1, 4'h0, 5'd0, 32'h0000_8001, 32'h500));
    step(1, mk(A_CMP, 0,0,0,0,0,1, 4'h0, 5'd0, 32'd10, 32'h504));
    first = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, '0);
      vectors++; if (has_int !== exp_has_int()) begin errors++; $display("FAIL timer_has_int cyc %0d: got %b want %b", i, has_int, exp_has_int()); end
      if (has_int === 1'b1 && first < 0) first = i;
    end
    vectors++; if (first < 0) begin errors++; $display("FAIL timer_fire: got no interrupt want one within 40 cycles"); end
    step(1, mk(A_CMP, 0,0,0,0,0,1, 4'h0, 5'd0, 32'd1000, 32'h508));
    step(1, mk(A_CA,  0,0,0,0,1,0, 4'hF, 5'd8, 32'h0, 32'h50C));
    vectors++; if (has_int !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b want 0", has_int); end
    vectors++; if (rf_wdata[30] !== 1'b0 || rf_wdata[15] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear: got %h want TI=0", rf_wdata); end
  endtask

  task automatic test_reset_mid();
    step(1, mk(A_EPC, 0,0,0,0,0,1, 4'hF, 5'd9, 32'h1234_5678, 32'h600));
    vectors++; if (rf_we !== 4'hF) begin errors++; $display("FAIL mid_held_we: got %b want 1111", rf_we); end
    reset = 1;
    step(0, '0);
    vectors++; if (rf_we !== 4'h0) begin errors++; $display("FAIL mid_reset_we: got %b want 0", rf_we); end
    vectors++; if (cp0_epc !== 32'h0) begin errors++; $display("FAIL mid_reset_epc: got %h want 0", cp0_epc); end
    reset = 0;
    step(1, mk(A_ST, 0,0,0,0,1,0, 4'hF, 5'd9, 32'h0, 32'h604));
    vectors++; if (rf_wdata !== 32'h0040_0000) begin errors++; $display("FAIL mid_reset_status: got %h want 00400000", rf_wdata); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [6];
    logic [7:0] a;
    logic       v;
    int         kind;
    addrs[0] = A_CNT; addrs[1] = A_CMP; addrs[2] = A_ST;
    addrs[3] = A_CA;  addrs[4] = A_EPC; addrs[5] = A_BAD;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 5);
      a    = addrs[$urandom_range(0, 5)];
      case (kind)
        0, 1: step(v, mk(8'h0, 0,0,0,0,0,0, 4'($urandom), 5'($urandom), $urandom, $urandom));
        2:    step(v, mk(a, 0,0,0,0,1,0, 4'($urandom), 5'($urandom), $urandom, $urandom));
        3:    step(v, mk(a, 0,0,0,0,0,1, 4'h0, 5'd0,
                         (a == A_CMP || a == A_CNT) ? 32'($urandom_range(0, 40)) : $urandom, $urandom));
        4:    step(v, mk(a, 1, 1'($urandom), 0, 1'($urandom), 0, 1'($urandom),
                         4'($urandom), 5'($urandom), $urandom, $urandom));
        default: step(v, mk(8'h0, 0,0,1,0,0,0, 4'h0, 5'd0, 32'h0, $urandom));
      endcase
      vectors++; if (rf_we !== exp_we()) begin errors++; $display("FAIL rnd_rf_we %0d: got %b want %b", i, rf_we, exp_we()); end
      vectors++; if (ws_ex !== (m_valid && m_bus[78])) begin errors++; $display("FAIL rnd_ws_ex %0d: got %b want %b", i, ws_ex, m_valid && m_bus[78]); end
      vectors++; if (eret_flush !== (m_valid && m_bus[76])) begin errors++; $display("FAIL rnd_eret %0d: got %b want %b", i, eret_flush, m_valid && m_bus[76]); end
      vectors++; if (cp0_epc !== m_epc) begin errors++; $display("FAIL rnd_epc %0d: got %h want %h", i, cp0_epc, m_epc); end
      vectors++; if (has_int !== exp_has_int()) begin errors++; $display("FAIL rnd_has_int %0d: got %b want %b", i, has_int, exp_has_int()); end
      if (m_valid) begin
        vectors++; if (rf_wdata !== exp_wdata()) begin errors++; $display("FAIL rnd_rf_wdata %0d: got %h want %h", i, rf_wdata, exp_wdata()); end
        vectors++; if (ws_fwd_blk_bus !== {exp_we(), m_bus[68:64], exp_wdata()}) begin errors++; $display("FAIL rnd_fwd %0d: got %h", i, ws_fwd_blk_bus); end
        vectors++; if (debug_wb_pc !== m_bus[31:0] || debug_wb_rf_wnum !== m_bus[68:64]) begin errors++; $display("FAIL rnd_debug %0d: got %h/%0d want %h/%0d", i, debug_wb_pc, debug_wb_rf_wnum, m_bus[31:0], m_bus[68:64]); end
      end else begin
        vectors++; if (ws_fwd_blk_bus[40:37] !== 4'h0) begin errors++; $display("FAIL rnd_fwd_idle %0d: got %b want 0", i, ws_fwd_blk_bus[40:37]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      step(1, mk(8'h0, 0,0,0,0,0,0, 4'hF, 5'(i + 1), d, 32'(i * 4)));
      vectors++; if (rf_wdata !== d || rf_waddr !== 5'(i + 1) || rf_we !== 4'hF) begin errors++; $display("FAIL b2b %0d: got %h/%0d/%b want %h/%0d/1111", i, rf_wdata, rf_waddr, rf_we, d, i + 1); end
    end
  endtask

  initial begin
    reset = 1;
    ms_to_ws_valid = 0;
    ms_to_ws_bus = '0;
    model_reset();
    m_bus = '0;
    test_reset();
    test_load();
    test_syscall();
    test_eret();
    test_mfc0_masks();
    test_timer();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
